// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, signed or unsigned, one quotient
// bit per clock, MSB first.
//
// Ports
//   Clock        rising-edge clock
//   Reset        asynchronous active-high reset
//   Start        request, accepted only while idle
//   Signed_Mode  1 = two's-complement operands, 0 = unsigned (taken with Start)
//   A, B         dividend / divisor (taken with Start)
//   Busy         high while dividing or applying sign correction
//   Done         one-cycle pulse when results are updated (or divide-by-zero)
//   Div_Zero     one-cycle pulse with Done when the captured divisor was zero
//   HI_Out       remainder
//   LO_Out       quotient
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for Start
// CALC  | restoring iterations, WIDTH cycles
// FIX   | sign-correct quotient/remainder, publish results, pulse Done
// DONE  | divisor was zero: pulse Done and Div_Zero, results untouched

module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed_Mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             Div_Zero,
    output logic [WIDTH-1:0] HI_Out,
    output logic [WIDTH-1:0] LO_Out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             neg_q;
    logic             neg_r;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a_in;
    logic [WIDTH-1:0] mag_b_in;
    logic [WIDTH:0]   part;
    logic [WIDTH:0]   diff;
    logic             fit;
    logic             cnt_tc;

    // The most negative value negates to itself, which is exactly its
    // magnitude when read as an unsigned WIDTH-bit number.
    always_comb begin
        a_neg    = Signed_Mode & A[WIDTH-1];
        b_neg    = Signed_Mode & B[WIDTH-1];
        mag_a_in = a_neg ? -A : A;
        mag_b_in = b_neg ? -B : B;
        part     = {rem, dvd[WIDTH-1]};
        diff     = part - {1'b0, mag_b};
        fit      = ~diff[WIDTH];
        cnt_tc   = (cnt == '0);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    state_nxt = (B == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_tc) begin
                    state_nxt = S_FIX;
                end
            end
            S_FIX:   state_nxt = S_IDLE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign Busy = (state == S_CALC) || (state == S_FIX);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cnt      <= '0;
            dvd      <= '0;
            mag_b    <= '0;
            quo      <= '0;
            rem      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            Done     <= 1'b0;
            Div_Zero <= 1'b0;
            HI_Out   <= '0;
            LO_Out   <= '0;
        end else begin
            Done     <= 1'b0;
            Div_Zero <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dvd   <= mag_a_in;
                        mag_b <= mag_b_in;
                        quo   <= '0;
                        rem   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                    end
                end
                S_CALC: begin
                    dvd <= {dvd[WIDTH-2:0], 1'b0};
                    quo <= {quo[WIDTH-2:0], fit};
                    rem <= fit ? diff[WIDTH-1:0] : part[WIDTH-1:0];
                    if (!cnt_tc) begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_FIX: begin
                    LO_Out <= neg_q ? -quo : quo;
                    HI_Out <= neg_r ? -rem : rem;
                    Done   <= 1'b1;
                end
                S_DONE: begin
                    Done     <= 1'b1;
                    Div_Zero <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 32;

    logic         Clock = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic         Signed_Mode = 1'b0;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Busy;
    logic         Done;
    logic         Div_Zero;
    logic [W-1:0] HI_Out;
    logic [W-1:0] LO_Out;

    int vectors = 0;
    int miscompares = 0;

    logic [W-1:0] exp_lo = '0;
    logic [W-1:0] exp_hi = '0;

    seq_divider #(.WIDTH(W)) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Start       (Start),
        .Signed_Mode (Signed_Mode),
        .A           (A),
        .B           (B),
        .Busy        (Busy),
        .Done        (Done),
        .Div_Zero    (Div_Zero),
        .HI_Out      (HI_Out),
        .LO_Out      (LO_Out)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division in 64-bit arithmetic. SystemVerilog
    // signed division truncates toward zero and the remainder takes the sign
    // of the dividend; MIN / -1 becomes +2^31, which wraps to MIN in 32 bits.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         output logic [W-1:0] q, output logic [W-1:0] r);
        longint sa, sb;
        longint unsigned ua, ub;
        if (sm) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            ua = {32'b0, a};
            ub = {32'b0, b};
            q  = W'(ua / ub);
            r  = W'(ua % ub);
        end
    endtask

    // Issues one operation and waits for Done. Operands are scrambled right
    // after the accepting edge; with interfere set, a second Start carrying
    // new operands is raised mid-operation.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                          input bit interfere, input string tag);
        logic [W-1:0] q, r;
        int k, busy_cnt, exp_lat, exp_busy;
        Start       = 1'b1;
        A           = a;
        B           = b;
        Signed_Mode = sm;
        @(posedge Clock);
        #1;
        Start       = 1'b0;
        A           = W'($urandom);
        B           = W'($urandom);
        Signed_Mode = ~sm;
        k = 0;
        busy_cnt = 0;
        while (Done !== 1'b1 && k < 100) begin
            if (Busy === 1'b1) busy_cnt++;
            if (interfere && k == 9) begin
                Start = 1'b1;
                A     = W'($urandom);
                B     = W'($urandom_range(1, 1000));
            end
            if (interfere && k == 10) Start = 1'b0;
            @(posedge Clock);
            #1;
            k++;
        end
        if (b != '0) begin
            model(a, b, sm, q, r);
            exp_lo   = q;
            exp_hi   = r;
            exp_lat  = W + 1;
            exp_busy = W + 1;
        end else begin
            exp_lat  = 1;
            exp_busy = 0;
        end
        check({tag, ".latency"}, 64'(k), 64'(exp_lat));
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        check({tag, ".lo"}, 64'(LO_Out), 64'(exp_lo));
        check({tag, ".hi"}, 64'(HI_Out), 64'(exp_hi));
        check({tag, ".div_zero"}, 64'(Div_Zero), 64'(b == '0));
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;
        int           done_seen;

        #2;
        check("reset.busy", 64'(Busy), 64'd0);
        check("reset.done", 64'(Done), 64'd0);
        check("reset.div_zero", 64'(Div_Zero), 64'd0);
        check("reset.lo", 64'(LO_Out), 64'd0);
        check("reset.hi", 64'(HI_Out), 64'd0);
        @(negedge Clock);
        Reset = 1'b0;

        run_op(32'd8, 32'd5, 1'b0, 1'b0, "u_8_5");
        run_op(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, "s_m7_2");
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b0, "s_7_m2");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, "s_min_m1");
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "u_min_max");
        run_op(32'd8, 32'd5, 1'b0, 1'b0, "u_8_5_again");
        run_op(32'd123, 32'd0, 1'b0, 1'b0, "div0");
        @(posedge Clock);
        #1;
        check("div0.done_drop", 64'(Done), 64'd0);
        check("div0.dz_drop", 64'(Div_Zero), 64'd0);
        run_op(32'd0, 32'd9, 1'b0, 1'b0, "u_0_9");
        run_op(32'hFFFF_FFFF, 32'h10, 1'b0, 1'b1, "u_busy_start");

        Start = 1'b1;
        A = 32'h0000_DEAD;
        B = 32'd7;
        Signed_Mode = 1'b0;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        repeat (15) @(posedge Clock);
        #1;
        Reset = 1'b1;
        #1;
        check("abort.busy", 64'(Busy), 64'd0);
        check("abort.done", 64'(Done), 64'd0);
        check("abort.lo", 64'(LO_Out), 64'd0);
        check("abort.hi", 64'(HI_Out), 64'd0);
        exp_lo = '0;
        exp_hi = '0;
        #2;
        Reset = 1'b0;
        done_seen = 0;
        repeat (40) begin
            @(posedge Clock);
            #1;
            if (Done === 1'b1) done_seen++;
        end
        check("abort.no_done", 64'(done_seen), 64'd0);
        run_op(32'd8, 32'd5, 1'b0, 1'b0, "after_abort");

        for (int i = 0; i < 20; i++) begin
            ra = W'($urandom);
            if ($urandom_range(0, 4) == 0) ra = 32'h8000_0000;
            if ($urandom_range(0, 2) == 0) rb = W'($urandom_range(0, 20));
            else rb = W'($urandom);
            if ($urandom_range(0, 3) == 0) rb = rb | 32'hFFFF_FF00;
            rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rs, 1'b0, $sformatf("rand%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
